// File: rtl/key_shift_loader.sv
// key_shift_loader
// Serial key loader sitting directly upstream of a locked netlist's key gates.
// The key arrives one bit at a time, MSB first, over a valid/ready handshake.
// The parallel key bus stays all-zeros until a load commits. Once committed,
// the key can only be cleared by reset.
//
// Optional feature: define KEY_PARITY_EN to append an even-parity bit to every
// load. Each parity failure is counted, and after MAX_RETRY failures the loader
// locks out until reset. Without the macro, every completed load commits.
module key_shift_loader #(
    parameter int KEY_W     = 64,
    parameter int MAX_RETRY = 3
) (
    input  logic             C,
    input  logic             R,
    input  logic             load_start,
    input  logic             sdata,
    input  logic             svalid,
    output logic             sready,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             key_err,
    output logic             lockout,
    output logic             busy
);

`ifdef KEY_PARITY_EN
    localparam int NBITS = KEY_W + 1;
`else
    localparam int NBITS = KEY_W;
`endif
    localparam int CNT_W = $clog2(NBITS + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SHIFT  = 3'd1;
    localparam logic [2:0] CHECK  = 3'd2;
    localparam logic [2:0] LOCKED = 3'd3;
    localparam logic [2:0] ERROR  = 3'd4;
    localparam logic [2:0] DEAD   = 3'd5;

    if (KEY_W < 2 || MAX_RETRY < 1) begin : g_bad_param
        $error("key_shift_loader: KEY_W must be >= 2 and MAX_RETRY must be >= 1");
    end

    logic [2:0]       state;
    logic [KEY_W-1:0] shreg;
    logic [CNT_W-1:0] count;
    logic             start_load;
    logic             accept;
    logic             last_bit;
    logic             check_pass;
    logic             fail_dead;

    // A start request only has an effect where a load may begin or restart;
    // LOCKED and DEAD ignore it.
    assign start_load = load_start && (state == IDLE || state == SHIFT || state == ERROR);
    // A restart has priority over a bit offered in the same cycle, so that bit is dropped.
    assign accept     = (state == SHIFT) && svalid && !load_start;
    assign last_bit   = accept && (count == CNT_W'(NBITS - 1));

`ifdef KEY_PARITY_EN
    localparam int ERR_W = $clog2(MAX_RETRY + 1);

    logic             par;
    logic [ERR_W-1:0] err_cnt;

    // Running XOR of every accepted bit, including the trailing parity bit.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            par <= 1'b0;
        end else if (start_load) begin
            par <= 1'b0;
        end else if (accept) begin
            par <= par ^ sdata;
        end
    end

    // Saturating count of failed checks; only reset clears it.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            err_cnt <= '0;
        end else if (state == CHECK && !check_pass && int'(err_cnt) < MAX_RETRY) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end

    assign check_pass = ~par;
    assign fail_dead  = (int'(err_cnt) + 1 >= MAX_RETRY);
`else
    assign check_pass = 1'b1;
    assign fail_dead  = 1'b0;
`endif

    // Load sequencing: state, data shift register, and handshake counter.
    // NOTE: all state updates here are non-blocking. Each branch then reads
    // the values from before the edge, whatever order the statements are in.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state <= IDLE;
            shreg <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE, ERROR: begin
                    if (load_start) begin
                        state <= SHIFT;
                        shreg <= '0;
                        count <= '0;
                    end
                end
                SHIFT: begin
                    if (load_start) begin
                        shreg <= '0;
                        count <= '0;
                    end else if (accept) begin
                        // The parity bit is counted but never enters the key.
                        if (int'(count) < KEY_W) begin
                            shreg <= {shreg[KEY_W-2:0], sdata};
                        end
                        count <= count + CNT_W'(1);
                        if (last_bit) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (check_pass) begin
                        state <= LOCKED;
                    end else if (fail_dead) begin
                        state <= DEAD;
                    end else begin
                        state <= ERROR;
                    end
                end
                LOCKED, DEAD: state <= state;
                default: state <= IDLE;
            endcase
        end
    end

    // Every output is decoded from registered state only, with no input-to-output path.
    assign sready    = (state == SHIFT);
    assign busy      = (state == SHIFT) || (state == CHECK);
    assign key_valid = (state == LOCKED);
    assign key       = key_valid ? shreg : '0;
`ifdef KEY_PARITY_EN
    assign key_err   = (state == ERROR) || (state == DEAD);
    assign lockout   = (state == DEAD);
`else
    assign key_err   = 1'b0;
    assign lockout   = 1'b0;
`endif

endmodule

// File: tb/tb_key_shift_loader.sv
// Self-checking bench for key_shift_loader (KEY_W=8, MAX_RETRY=3).
// Expected outputs come from the load rules directly: a key is committed
// one cycle after its last bit, and parity or lockout outcomes come from a
// simple failure count. The bench follows KEY_PARITY_EN like the design does.
module tb_key_shift_loader;
    localparam int KEY_W     = 8;
    localparam int MAX_RETRY = 3;
`ifdef KEY_PARITY_EN
    localparam int NBITS = KEY_W + 1;
`else
    localparam int NBITS = KEY_W;
`endif
    localparam int OUT_W = KEY_W + 5;

    logic             C          = 1'b0;
    logic             R          = 1'b0;
    logic             load_start = 1'b0;
    logic             sdata      = 1'b0;
    logic             svalid     = 1'b0;
    logic             sready;
    logic [KEY_W-1:0] key;
    logic             key_valid;
    logic             key_err;
    logic             lockout;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    key_shift_loader #(.KEY_W(KEY_W), .MAX_RETRY(MAX_RETRY)) dut (
        .C(C), .R(R), .load_start(load_start), .sdata(sdata), .svalid(svalid),
        .sready(sready), .key(key), .key_valid(key_valid), .key_err(key_err),
        .lockout(lockout), .busy(busy)
    );

    always #5 C = ~C;

    function automatic logic [OUT_W-1:0] observed();
        return {key, key_valid, key_err, lockout, busy, sready};
    endfunction

    function automatic logic [OUT_W-1:0] expect_out(input logic [KEY_W-1:0] k,
                                                    input bit kv, ke, lo, bz, sr);
        return {k, kv, ke, lo, bz, sr};
    endfunction

    // Serial frame for a data word: the data MSB first, then an even-parity bit if enabled.
    function automatic logic [NBITS-1:0] frame(input logic [KEY_W-1:0] d);
`ifdef KEY_PARITY_EN
        return {d, ^d};
`else
        return d;
`endif
    endfunction

    task automatic step();
        @(posedge C);
        #1;
    endtask

    task automatic do_reset();
        R = 1'b0; load_start = 1'b0; svalid = 1'b0; sdata = 1'b0;
        step();
        step();
        R = 1'b1;
        step();
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    // Offer the top n bits of frame f, with lo..hi idle cycles before each bit.
    task automatic shift_bits(input logic [NBITS-1:0] f, input int n, input int lo, input int hi);
        int gap;
        for (int i = NBITS - 1; i >= NBITS - n; i--) begin
            gap = $urandom_range(hi, lo);
            repeat (gap) begin
                step();
                checks++;
                if (sready !== 1'b1 || busy !== 1'b1 || key_valid !== 1'b0 || key !== '0) begin
                    failures++;
                    $display("FAIL shift_gap: sready=%b busy=%b key_valid=%b key=%h, want 1 1 0 00",
                             sready, busy, key_valid, key);
                end
            end
            sdata  = f[i];
            svalid = 1'b1;
            step();
            svalid = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [OUT_W-1:0] exp;
        R = 1'b0;
        #1;
        exp = expect_out('0, 0, 0, 0, 0, 0);
        checks++;
        if (observed() !== exp) begin
            failures++;
            $display("FAIL reset_state: got %h want %h", observed(), exp);
        end
        do_reset();
        svalid = 1'b1; sdata = 1'b1;
        repeat (3) step();
        svalid = 1'b0;
        checks++;
        if (observed() !== exp) begin
            failures++;
            $display("FAIL idle_ignores_svalid: got %h want %h", observed(), exp);
        end
    endtask

    task automatic test_basic_load();
        logic [OUT_W-1:0] exp;
        do_reset();
        start_load();
        exp = expect_out('0, 0, 0, 0, 1, 1);
        checks++;
        if (observed() !== exp) begin
            failures++;
            $display("FAIL start_to_shift: got %h want %h", observed(), exp);
        end
        shift_bits(frame(8'hA5), NBITS, 0, 0);
        exp = expect_out('0, 0, 0, 0, 1, 0);
        checks++;
        if (observed() !== exp) begin
            failures++;
            $display("FAIL check_cycle: got %h want %h", observed(), exp);
        end
        step();
        exp = expect_out(8'hA5, 1, 0, 0, 0, 0);
        checks++;
        if (observed() !== exp) begin
            failures++;
            $display("FAIL commit_a5: got %h want %h", observed(), exp);
        end
        step();
        checks++;
        if (observed() !== exp) begin
            failures++;
            $display("FAIL commit_a5_hold: got %h want %h", observed(), exp);
        end
    endtask

    task automatic test_gaps();
        logic [OUT_W-1:0] exp;
        logic [KEY_W-1:0] d;
        do_reset();
        start_load();
        shift_bits(frame(8'h3C), NBITS, 3, 3);
        step();
        exp = expect_out(8'h3C, 1, 0, 0, 0, 0);
        checks++;
        if (observed() !== exp) begin
            failures++;
            $display("FAIL gaps_3c: got %h want %h", observed(), exp);
        end
        for (int t = 0; t < 5; t++) begin
            d = KEY_W'($urandom);
            do_reset();
            start_load();
            shift_bits(frame(d), NBITS, 0, 4);
            step();
            exp = expect_out(d, 1, 0, 0, 0, 0);
            checks++;
            if (observed() !== exp) begin
                failures++;
                $display("FAIL gaps_random[%0d]: got %h want %h", t, observed(), exp);
            end
        end
    endtask

    task automatic test_restart();
        logic [OUT_W-1:0] exp;
        do_reset();
        // load_start together with svalid in IDLE: that bit must not be taken.
        svalid = 1'b1; sdata = 1'b1;
        start_load();
        svalid = 1'b0;
        shift_bits(frame(KEY_W'($urandom)), 3, 0, 1);
        // Restart with a bit offered in the same cycle: that bit is dropped.
        svalid = 1'b1; sdata = 1'b1;
        start_load();
        svalid = 1'b0;
        exp = expect_out('0, 0, 0, 0, 1, 1);
        checks++;
        if (observed() !== exp) begin
            failures++;
            $display("FAIL restart_in_shift: got %h want %h", observed(), exp);
        end
        shift_bits(frame(8'hF0), NBITS, 0, 1);
        step();
        exp = expect_out(8'hF0, 1, 0, 0, 0, 0);
        checks++;
        if (observed() !== exp) begin
            failures++;
            $display("FAIL restart_f0: got %h want %h", observed(), exp);
        end
        for (int t = 0; t < 6; t++) begin
            load_start = 1'($urandom);
            svalid     = 1'b1;
            sdata      = 1'($urandom);
            step();
        end
        load_start = 1'b0; svalid = 1'b0;
        checks++;
        if (observed() !== exp) begin
            failures++;
            $display("FAIL locked_ignores_inputs: got %h want %h", observed(), exp);
        end
    endtask

`ifdef KEY_PARITY_EN
    task automatic test_parity();
        logic [OUT_W-1:0] exp;
        do_reset();
        start_load();
        shift_bits(frame(8'hA5) ^ NBITS'(1), NBITS, 0, 0);
        step();
        exp = expect_out('0, 0, 1, 0, 0, 0);
        checks++;
        if (observed() !== exp) begin
            failures++;
            $display("FAIL bad_parity_a5: got %h want %h", observed(), exp);
        end
        start_load();
        exp = expect_out('0, 0, 0, 0, 1, 1);
        checks++;
        if (observed() !== exp) begin
            failures++;
            $display("FAIL retry_clears_err: got %h want %h", observed(), exp);
        end
        shift_bits(frame(8'hA5), NBITS, 0, 0);
        step();
        exp = expect_out(8'hA5, 1, 0, 0, 0, 0);
        checks++;
        if (observed() !== exp) begin
            failures++;
            $display("FAIL good_parity_a5: got %h want %h", observed(), exp);
        end
    endtask

    task automatic test_lockout();
        logic [OUT_W-1:0] exp;
        logic [KEY_W-1:0] d;
        int fails;
        do_reset();
        fails = 0;
        for (int a = 0; a < MAX_RETRY; a++) begin
            start_load();
            shift_bits(frame(KEY_W'($urandom)) ^ NBITS'(1), NBITS, 0, 2);
            step();
            fails++;
            exp = expect_out('0, 0, 1, (fails >= MAX_RETRY), 0, 0);
            checks++;
            if (observed() !== exp) begin
                failures++;
                $display("FAIL bad_load[%0d]: got %h want %h", a, observed(), exp);
            end
        end
        exp = expect_out('0, 0, 1, 1, 0, 0);
        for (int t = 0; t < 8; t++) begin
            load_start = 1'($urandom);
            svalid     = 1'($urandom);
            sdata      = 1'($urandom);
            step();
        end
        load_start = 1'b0; svalid = 1'b0;
        checks++;
        if (observed() !== exp) begin
            failures++;
            $display("FAIL dead_ignores_inputs: got %h want %h", observed(), exp);
        end
        // A good load before the final allowed failure still commits.
        do_reset();
        for (int a = 0; a < MAX_RETRY - 1; a++) begin
            start_load();
            shift_bits(frame(KEY_W'($urandom)) ^ NBITS'(1), NBITS, 0, 1);
            step();
        end
        d = KEY_W'($urandom);
        start_load();
        shift_bits(frame(d), NBITS, 0, 1);
        step();
        exp = expect_out(d, 1, 0, 0, 0, 0);
        checks++;
        if (observed() !== exp) begin
            failures++;
            $display("FAIL good_after_retries: got %h want %h", observed(), exp);
        end
    endtask
`endif

    task automatic test_async_reset();
        logic [OUT_W-1:0] exp;
        do_reset();
        start_load();
        shift_bits(frame(8'hC3), 4, 0, 0);
        #2;
        R = 1'b0;
        #1;
        exp = expect_out('0, 0, 0, 0, 0, 0);
        checks++;
        if (observed() !== exp) begin
            failures++;
            $display("FAIL async_reset_shift: got %h want %h", observed(), exp);
        end
        R = 1'b1;
        step();
        start_load();
        shift_bits(frame(8'h5A), NBITS, 0, 2);
        step();
        exp = expect_out(8'h5A, 1, 0, 0, 0, 0);
        checks++;
        if (observed() !== exp) begin
            failures++;
            $display("FAIL reload_after_shift_reset: got %h want %h", observed(), exp);
        end
        #2;
        R = 1'b0;
        #1;
        exp = expect_out('0, 0, 0, 0, 0, 0);
        checks++;
        if (observed() !== exp) begin
            failures++;
            $display("FAIL async_reset_locked: got %h want %h", observed(), exp);
        end
        R = 1'b1;
        step();
        start_load();
        shift_bits(frame(8'h5A), NBITS, 0, 2);
        step();
        exp = expect_out(8'h5A, 1, 0, 0, 0, 0);
        checks++;
        if (observed() !== exp) begin
            failures++;
            $display("FAIL reload_after_locked_reset: got %h want %h", observed(), exp);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_gaps();
        test_restart();
`ifdef KEY_PARITY_EN
        test_parity();
        test_lockout();
`endif
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
